// File: rtl/wb_stage.sv
// Writeback stage: registers the MEM-stage result, formats load data and
// drives the register-file write port. Keeps a retired-instruction count.
// Optional sub-word load formatting is enabled by defining WB_SUBWORD_LOAD_EN;
// without it every load returns the full memory word.
module wb_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        m_valid,
    input  logic        m_regwrite,
    input  logic        m_memtoreg,
    input  logic [4:0]  m_rd,
    input  logic [31:0] m_alu_result,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_ldsize,
    input  logic        m_ldunsigned,
    output logic        we3,
    output logic [4:0]  wa3,
    output logic [31:0] wd3,
    output logic        wb_valid,
    output logic [31:0] retired
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;

    logic          valid_q,      valid_d;
    logic          regwrite_q,   regwrite_d;
    logic          memtoreg_q,   memtoreg_d;
    logic [AW-1:0] rd_q,         rd_d;
    logic [DW-1:0] alu_q,        alu_d;
    logic [DW-1:0] rdata_q,      rdata_d;
    logic [DW-1:0] retired_q,    retired_d;

`ifdef WB_SUBWORD_LOAD_EN
    logic [1:0]    ldsize_q,     ldsize_d;
    logic          ldunsigned_q, ldunsigned_d;
`else
    // Size/sign controls have no effect when sub-word loads are disabled.
    logic          unused_ld_ctrl;
    assign unused_ld_ctrl = ^{m_ldsize, m_ldunsigned};
`endif

    logic [DW-1:0] load_data;

    // Next-state: flush beats stall beats capture; retire when the held instruction leaves.
    always_comb begin
        valid_d      = valid_q;
        regwrite_d   = regwrite_q;
        memtoreg_d   = memtoreg_q;
        rd_d         = rd_q;
        alu_d        = alu_q;
        rdata_d      = rdata_q;
`ifdef WB_SUBWORD_LOAD_EN
        ldsize_d     = ldsize_q;
        ldunsigned_d = ldunsigned_q;
`endif
        retired_d    = retired_q;

        if (flush_i) begin
            valid_d = 1'b0;
        end else if (!stall_i) begin
            valid_d      = m_valid;
            regwrite_d   = m_regwrite;
            memtoreg_d   = m_memtoreg;
            rd_d         = m_rd;
            alu_d        = m_alu_result;
            rdata_d      = m_rdata;
`ifdef WB_SUBWORD_LOAD_EN
            ldsize_d     = m_ldsize;
            ldunsigned_d = m_ldunsigned;
`endif
        end

        if (valid_q && (!stall_i || flush_i)) begin
            retired_d = retired_q + DW'(1);
        end
    end

    // WB pipeline register and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            regwrite_q   <= 1'b0;
            memtoreg_q   <= 1'b0;
            rd_q         <= '0;
            alu_q        <= '0;
            rdata_q      <= '0;
`ifdef WB_SUBWORD_LOAD_EN
            ldsize_q     <= '0;
            ldunsigned_q <= 1'b0;
`endif
            retired_q    <= '0;
        end else begin
            valid_q      <= valid_d;
            regwrite_q   <= regwrite_d;
            memtoreg_q   <= memtoreg_d;
            rd_q         <= rd_d;
            alu_q        <= alu_d;
            rdata_q      <= rdata_d;
`ifdef WB_SUBWORD_LOAD_EN
            ldsize_q     <= ldsize_d;
            ldunsigned_q <= ldunsigned_d;
`endif
            retired_q    <= retired_d;
        end
    end

`ifdef WB_SUBWORD_LOAD_EN
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Load formatting: lane select by address, then zero/sign extension.
    always_comb begin
        byte_sel  = 8'h00;
        half_sel  = 16'h0000;
        load_data = rdata_q;

        case (alu_q[1:0])
            2'd0:    byte_sel = rdata_q[7:0];
            2'd1:    byte_sel = rdata_q[15:8];
            2'd2:    byte_sel = rdata_q[23:16];
            default: byte_sel = rdata_q[31:24];
        endcase

        // Address bit 0 is ignored for halves; misalignment is not trapped here.
        half_sel = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];

        case (ldsize_q)
            LD_BYTE: load_data = ldunsigned_q ? {24'h000000, byte_sel}
                                              : {{24{byte_sel[7]}}, byte_sel};
            LD_HALF: load_data = ldunsigned_q ? {16'h0000, half_sel}
                                              : {{16{half_sel[15]}}, half_sel};
            default: load_data = rdata_q;
        endcase
    end
`else
    // Full-word loads only.
    always_comb begin
        load_data = rdata_q;
    end
`endif

    // Register-file write port, driven purely from WB state; x0 writes suppressed.
    always_comb begin
        we3 = valid_q && regwrite_q && (rd_q != AW'(0));
        wa3 = rd_q;
        wd3 = memtoreg_q ? load_data : alu_q;
    end

    assign wb_valid = valid_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: table of single-instruction vectors plus hand-written
// stall/flush, reset and counter-wrap sequences. Expected load data follows
// WB_SUBWORD_LOAD_EN when the bench is compiled with it.
module tb_wb_stage;

`ifdef WB_SUBWORD_LOAD_EN
    localparam bit SUB = 1'b1;
`else
    localparam bit SUB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i;
    logic        m_valid, m_regwrite, m_memtoreg;
    logic [4:0]  m_rd;
    logic [31:0] m_alu_result, m_rdata;
    logic [1:0]  m_ldsize;
    logic        m_ldunsigned;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic        wb_valid;
    logic [31:0] retired;

    int n_vec = 0;
    int n_err = 0;

    // Reference state for valid bit and retire count.
    logic        mdl_valid;
    logic [31:0] exp_ret;

    wb_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .m_valid      (m_valid),
        .m_regwrite   (m_regwrite),
        .m_memtoreg   (m_memtoreg),
        .m_rd         (m_rd),
        .m_alu_result (m_alu_result),
        .m_rdata      (m_rdata),
        .m_ldsize     (m_ldsize),
        .m_ldunsigned (m_ldunsigned),
        .we3          (we3),
        .wa3          (wa3),
        .wd3          (wd3),
        .wb_valid     (wb_valid),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1);
    end

    typedef struct {
        logic        v, rw, m2r;
        logic [4:0]  rd;
        logic [31:0] alu, rdata;
        logic [1:0]  sz;
        logic        uns;
        logic        e_we;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic v, logic rw, logic m2r, logic [4:0] rd,
                                logic [31:0] alu, logic [31:0] rdata,
                                logic [1:0] sz, logic uns,
                                logic e_we, logic [31:0] e_wd);
        vec_t t;
        t.v = v; t.rw = rw; t.m2r = m2r; t.rd = rd; t.alu = alu;
        t.rdata = rdata; t.sz = sz; t.uns = uns; t.e_we = e_we; t.e_wd = e_wd;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rdata,
                         input logic [1:0] sz, input logic uns);
        m_valid = v; m_regwrite = rw; m_memtoreg = m2r; m_rd = rd;
        m_alu_result = alu; m_rdata = rdata; m_ldsize = sz; m_ldunsigned = uns;
    endtask

    // One rising edge with the given controls; the model tracks valid and retire count.
    task automatic tick(input logic st, input logic fl);
        stall_i = st;
        flush_i = fl;
        if (mdl_valid && (!st || fl)) exp_ret = exp_ret + 32'd1;
        if (fl) mdl_valid = 1'b0;
        else if (!st) mdl_valid = m_valid;
        @(posedge clk);
        #1;
    endtask

    logic        h_we;
    logic [4:0]  h_wa;
    logic [31:0] h_wd;
    localparam logic [31:0] RD = 32'h80FF7F01;

    initial begin
        vecs[0]  = mk(1, 1, 0, 5'd5,  32'h0000_1234, 32'h0,       2'b10, 0, 1, 32'h0000_1234);
        vecs[1]  = mk(1, 1, 0, 5'd0,  32'h0000_1234, 32'h0,       2'b10, 0, 0, 32'h0000_1234);
        vecs[2]  = mk(1, 0, 0, 5'd7,  32'hCAFE_0001, 32'h0,       2'b10, 0, 0, 32'hCAFE_0001);
        vecs[3]  = mk(0, 1, 0, 5'd3,  32'h0000_0042, 32'h0,       2'b10, 0, 0, 32'h0000_0042);
        vecs[4]  = mk(1, 1, 1, 5'd9,  32'h0000_0000, 32'hDEADBEEF, 2'b10, 0, 1, 32'hDEADBEEF);
        vecs[5]  = mk(1, 1, 1, 5'd9,  32'h0000_0002, RD, 2'b00, 0, 1, SUB ? 32'hFFFF_FFFF : RD);
        vecs[6]  = mk(1, 1, 1, 5'd10, 32'h0000_0003, RD, 2'b00, 1, 1, SUB ? 32'h0000_0080 : RD);
        vecs[7]  = mk(1, 1, 1, 5'd11, 32'h0000_0000, RD, 2'b01, 0, 1, SUB ? 32'h0000_7F01 : RD);
        vecs[8]  = mk(1, 1, 1, 5'd12, 32'h0000_0003, RD, 2'b01, 0, 1, SUB ? 32'hFFFF_80FF : RD);
        vecs[9]  = mk(1, 1, 1, 5'd13, 32'h0000_0002, RD, 2'b01, 1, 1, SUB ? 32'h0000_80FF : RD);
        vecs[10] = mk(1, 1, 1, 5'd14, 32'h0000_0001, RD, 2'b00, 0, 1, SUB ? 32'h0000_007F : RD);
        vecs[11] = mk(1, 1, 1, 5'd15, 32'h0000_0000, RD, 2'b00, 1, 1, SUB ? 32'h0000_0001 : RD);
        vecs[12] = mk(1, 1, 1, 5'd31, 32'h0000_0001, RD, 2'b11, 0, 1, RD);

        // Reset state.
        rst_n = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        drive(1, 1, 0, 5'd5, 32'h1111_1111, 32'h2222_2222, 2'b10, 0);
        mdl_valid = 1'b0; exp_ret = 32'd0;
        #3;
        chk("reset_we3", 32'(we3), 32'd0);
        chk("reset_wa3", 32'(wa3), 32'd0);
        chk("reset_wd3", wd3, 32'd0);
        chk("reset_valid", 32'(wb_valid), 32'd0);
        chk("reset_retired", retired, 32'd0);
        @(posedge clk); #1;
        chk("reset_hold_valid", 32'(wb_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single-instruction vectors, back to back.
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v, vecs[i].rw, vecs[i].m2r, vecs[i].rd,
                  vecs[i].alu, vecs[i].rdata, vecs[i].sz, vecs[i].uns);
            tick(1'b0, 1'b0);
            chk($sformatf("v%0d_we3", i), 32'(we3), 32'(vecs[i].e_we));
            chk($sformatf("v%0d_wa3", i), 32'(wa3), 32'(vecs[i].rd));
            chk($sformatf("v%0d_wd3", i), wd3, vecs[i].e_wd);
            chk($sformatf("v%0d_valid", i), 32'(wb_valid), 32'(vecs[i].v));
            chk($sformatf("v%0d_retired", i), retired, exp_ret);
        end

        // Stall for three cycles: outputs frozen, count frozen.
        drive(1, 1, 0, 5'd12, 32'hAAAA_5555, 32'h0, 2'b10, 0);
        tick(1'b0, 1'b0);
        h_we = we3; h_wa = wa3; h_wd = wd3;
        chk("pre_stall_we3", 32'(h_we), 32'd1);
        chk("pre_stall_wd3", h_wd, 32'hAAAA_5555);
        drive(1, 1, 0, 5'd1, 32'h0BAD_0BAD, 32'h0, 2'b10, 0);
        for (int c = 0; c < 3; c++) begin
            tick(1'b1, 1'b0);
            chk($sformatf("stall%0d_we3", c), 32'(we3), 32'd1);
            chk($sformatf("stall%0d_wa3", c), 32'(wa3), 32'd12);
            chk($sformatf("stall%0d_wd3", c), wd3, 32'hAAAA_5555);
            chk($sformatf("stall%0d_retired", c), retired, exp_ret);
        end
        // Flush with stall: instruction leaves and counts.
        tick(1'b1, 1'b1);
        chk("flush_valid", 32'(wb_valid), 32'd0);
        chk("flush_we3", 32'(we3), 32'd0);
        chk("flush_retired", retired, exp_ret);
        // Bubble leaving WB is not counted.
        tick(1'b0, 1'b0);
        chk("after_flush_retired", retired, exp_ret);
        chk("after_flush_valid", 32'(wb_valid), 32'd1);

        // Reset mid-stall: drops the instruction without a count.
        tick(1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_we3", 32'(we3), 32'd0);
        chk("midrst_wa3", 32'(wa3), 32'd0);
        chk("midrst_wd3", wd3, 32'd0);
        chk("midrst_valid", 32'(wb_valid), 32'd0);
        chk("midrst_retired", retired, 32'd0);
        mdl_valid = 1'b0; exp_ret = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        // First edge after reset release captures.
        drive(1, 1, 0, 5'd6, 32'h0000_0777, 32'h0, 2'b10, 0);
        tick(1'b0, 1'b0);
        chk("first_cap_we3", 32'(we3), 32'd1);
        chk("first_cap_wd3", wd3, 32'h0000_0777);
        chk("first_cap_retired", retired, 32'd0);

        // Counter wrap.
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        release dut.retired_q;
        exp_ret = 32'hFFFF_FFFF;
        chk("preset_retired", retired, 32'hFFFF_FFFF);
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0, 2'b10, 0);
        tick(1'b0, 1'b0);
        chk("wrap_retired", retired, 32'd0);
        chk("wrap_model", exp_ret, retired);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit data and 5-bit register address.
REQ-002 clk  input  1  single clock; all state SHALL update on rising edge only.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall_i  input  1  hold WB register contents.
REQ-005 flush_i  input  1  discard incoming MEM-stage instruction.
REQ-006 m_valid  input  1  MEM-stage instruction valid.
REQ-007 m_regwrite  input  1  instruction writes a register.
REQ-008 m_memtoreg  input  1  1 = load data result, 0 = ALU result.
REQ-009 m_rd  input  5  destination register.
REQ-010 m_alu_result  input  32  ALU result; also the load address.
REQ-011 m_rdata  input  32  raw aligned memory word.
REQ-012 m_ldsize  input  2  00 byte, 01 half, 10/11 word.
REQ-013 m_ldunsigned  input  1  1 = zero-extend, 0 = sign-extend.
REQ-014 we3  output  1  register-file write enable.
REQ-015 wa3  output  5  register-file write address.
REQ-016 wd3  output  32  register-file write data.
REQ-017 wb_valid  output  1  WB register holds a valid instruction.
REQ-018 retired  output  32  retired-instruction count.

Function
REQ-019 Each rising edge SHALL apply these priorities: flush_i clears the valid bit (other fields don't-care); else stall_i holds all WB state; else all m_* inputs are captured, with the valid bit loaded from m_valid.
REQ-020 we3, wa3 and wd3 SHALL be combinational from registered state only; latency from MEM inputs to outputs is exactly 1 cycle.
REQ-021 we3 SHALL equal wb_valid & regwrite & (rd != 0); wa3 SHALL equal the registered rd.
REQ-022 When memtoreg=0, wd3 SHALL equal the registered alu_result.
REQ-023 When memtoreg=1 with word size, wd3 SHALL equal the registered rdata.
REQ-024 Byte load: the selected byte SHALL be rdata[8*a+7:8*a], where a is alu_result[1:0]; extension follows ldunsigned.
REQ-025 Half load: the selected half SHALL be rdata[31:16] if alu_result[1]=1, else rdata[15:0].
REQ-026 A misaligned half load (alu_result[0]=1) SHALL ignore alu_result[0]; no exception is raised.
REQ-027 Under stall, we3 SHALL remain asserted with unchanged wa3/wd3; a repeated identical write is permitted.
REQ-028 retired SHALL increment by 1 on each rising edge where wb_valid=1 and (stall_i=0 or flush_i=1), i.e. when the current instruction leaves WB.
REQ-029 retired SHALL wrap from 32'hFFFFFFFF to 0.
REQ-030 Simultaneous flush_i and stall_i SHALL behave as flush_i alone.

Reset
REQ-031 While rst_n=0: valid=0, retired=0, and all data fields=0; hence we3=0, wa3=0, wd3=0, wb_valid=0.
REQ-032 Reset asserted mid-stall or mid-instruction SHALL drop that instruction with no write and no count.
REQ-033 The first capture SHALL occur on the first rising edge with rst_n=1.

Configuration
REQ-034 Macro WB_SUBWORD_LOAD_EN: when defined, REQ-024..026 apply.
REQ-035 When WB_SUBWORD_LOAD_EN is undefined, m_ldsize and m_ldunsigned SHALL be ignored and every load SHALL return the full rdata word; all other behaviour is unchanged.

Verification
REQ-036 ALU write: m_valid=1, regwrite=1, memtoreg=0, rd=5, alu=32'h1234 -> next cycle we3=1, wa3=5, wd3=32'h1234, retired increments one edge later.
REQ-037 x0 suppression: the same stimulus with rd=0 -> we3=0, wb_valid=1, retired still increments.
REQ-038 Sub-word load (macro on): rdata=32'h80FF7F01, alu=32'h2, byte signed -> wd3=32'hFFFFFFFF; alu=32'h3, byte unsigned -> 32'h00000080; alu=32'h0, half signed -> 32'h00007F01; with macro off all three -> 32'h80FF7F01.
REQ-039 Stall/flush: hold stall_i=1 for 3 cycles -> outputs constant and retired unchanged; then flush_i=1 and stall_i=1 -> wb_valid=0 next cycle and retired +1.
REQ-040 Reset and wrap: pulse rst_n low between clock edges -> outputs 0 immediately; force retired to 32'hFFFFFFFF, retire one instruction -> retired=0.
